// File: rtl/countdown_ctrl_pkg.sv
// Shared types and helpers for the countdown control stage.
package countdown_ctrl_pkg;

  // Controller states. INIT is the all-zero encoding so reset lands there.
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // $clog2 clamped to at least one bit so degenerate sizes still give a legal vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/countdown_ctrl_debounce.sv
// Button debouncer: 2-flop synchroniser, stability counter, and a
// one-cycle press pulse on each accepted 0->1 transition of the button level.
module btn_debounce
  import countdown_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned      CNT_W    = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic             press_q, press_d;

  // Next-state: synchronise, count mismatching samples, accept the new level, detect rising edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sync_d       = {sync_q[0], btn_raw};
    cnt_d        = '0;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    press_d      = stable_q & ~stable_dly_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown control stage: debounced start/reload buttons, IDLE/RUN/PAUSE/DONE
// controller, tick prescaler, and the registered set/tick pulses for the digit chain.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 100_000_000,
  parameter int unsigned TICK_HZ         = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_reload,
  input  logic zero,
  output logic set,
  output logic tick,
  output logic running,
  output logic done
);

  localparam int unsigned        TICK_DIV   = CLK_FREQ / TICK_HZ;
  localparam int unsigned        PRESC_W    = clog2_min1(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic start_press;
  logic reload_press;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               set_q, set_d;
  logic               tick_q, tick_d;
  logic               running_q, running_d;
  logic               done_q, done_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_start),
    .press   (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reload_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_reload),
    .press   (reload_press)
  );

  // Controller next-state and pulse generation; earlier branches take priority.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    set_d   = 1'b0;
    tick_d  = 1'b0;
    if (state_q == ST_INIT) begin
      // Load the digits once after every reset.
      set_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (reload_press) begin
      // Reload wins over a coincident start press, from any state.
      set_d   = 1'b1;
      presc_d = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_press) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          // Zero is checked before the prescaler so the digits never wrap.
          if (zero) begin
            state_d = ST_DONE;
          end else if (start_press) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            tick_d  = 1'b1;
            presc_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          // Prescaler holds, so the resumed tick period excludes the pause.
          if (start_press) begin
            state_d = ST_RUN;
          end
        end
        default: ;  // DONE: only reload leaves
      endcase
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // Controller state, prescaler and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      presc_q   <= '0;
      set_q     <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      set_q     <= set_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign set     = set_q;
  assign tick    = tick_q;
  assign running = running_q;
  assign done    = done_q;

endmodule
